// File: rtl/bloom_stream_scanner_if.sv
// NetFPGA-style 64-bit packet stream bundle snooped by bloom_stream_scanner.
// The scanner only observes the stream, so its slave modport is input-only.
interface bloom_stream_scanner_if;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;

  modport master (output in_data, output in_ctrl, output in_wr, output in_rdy);
  modport slave  (input in_data, input in_ctrl, input in_wr, input in_rdy);
endinterface

// File: rtl/bloom_stream_scanner.sv
// Stream snooper: fold-hashes payload words and checks them against a programmable Bloom filter.
// Define BLOOM_TAIL_MASK_EN to zero the invalid bytes of the last word before hashing.
module bloom_stream_scanner #(
  parameter int unsigned FILTER_AW  = 10,
  parameter int unsigned SKIP_WORDS = 2
) (
  input  logic                 clk,
  input  logic                 rst_bloom,
  bloom_stream_scanner_if.slave stream,
  input  logic                 prog_we,
  input  logic [FILTER_AW-1:0] prog_addr,
  input  logic                 prog_bit,
  output logic                 bloom_match,
  output logic                 scan_done,
  output logic [7:0]           words_hashed,
  output logic [2:0]           scan_state
);

  localparam int unsigned Depth = 1 << FILTER_AW;
  localparam int          CntW  = (SKIP_WORDS < 1) ? 1 : $clog2(SKIP_WORDS + 1);
  localparam int          IdxW  = (FILTER_AW < 2) ? 1 : $clog2(FILTER_AW);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StModhdr = 3'd1,
    StSkip   = 3'd2,
    StScan   = 3'd3,
    StDone   = 3'd4
  } state_t;

  state_t              state;
  logic [CntW-1:0]     skip_cnt;
  logic [Depth-1:0]    filter;
  logic                v1, eop1;
  logic [FILTER_AW-1:0] h0_r, h1_r;

  logic        beat, is_hdr, is_pay, is_last, hash_en, pkt_start, hit;
  logic [63:0] hash_data, hash_rev;

  // Bit i of the word lands on hash bit (i mod FILTER_AW), i.e. an XOR of FILTER_AW-wide slices.
  function automatic logic [FILTER_AW-1:0] fold(input logic [63:0] x);
    logic [FILTER_AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 64; i++) begin
      acc[IdxW'(i % FILTER_AW)] ^= x[6'(i)];
    end
    return acc;
  endfunction

  assign beat      = stream.in_wr && stream.in_rdy;
  assign is_hdr    = (stream.in_ctrl == 8'hFF);
  assign is_pay    = (stream.in_ctrl == 8'h00);
  assign is_last   = !is_hdr && !is_pay;
  assign pkt_start = beat && ((state == StIdle) || (state == StDone));
  assign hash_en   = beat && ((state == StScan) ||
                              ((SKIP_WORDS == 0) && is_pay && (state != StSkip)));

`ifdef BLOOM_TAIL_MASK_EN
  // Byte i (byte 0 is the MSB) is valid when any ctrl bit in [7-i:0] is set.
  for (genvar i = 0; i < 8; i++) begin : g_tail_mask
    assign hash_data[63-8*i -: 8] = (is_last && ~|(stream.in_ctrl & (8'hFF >> i))) ?
                                    8'h00 : stream.in_data[63-8*i -: 8];
  end
`else
  assign hash_data = stream.in_data;
`endif

  assign hash_rev = {<<8{hash_data}};

  always_ff @(posedge clk or posedge rst_bloom) begin
    if (rst_bloom) begin
      state    <= StIdle;
      skip_cnt <= '0;
    end else if (beat) begin
      if (is_last) begin
        state <= StDone;
      end else begin
        case (state)
          StIdle, StModhdr, StDone: begin
            if (is_hdr) begin
              state <= StModhdr;
            end else begin
              skip_cnt <= CntW'(1);
              state    <= (SKIP_WORDS <= 1) ? StScan : StSkip;
            end
          end
          StSkip: begin
            if (is_pay) begin
              skip_cnt <= skip_cnt + 1'b1;
              if (int'(skip_cnt) + 1 >= int'(SKIP_WORDS)) state <= StScan;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign scan_state = state;

  // Deliberately outside rst_bloom: the reset fires per packet, the filter is software state.
  always_ff @(posedge clk) begin
    if (prog_we) filter[prog_addr] <= prog_bit;
  end

  always_ff @(posedge clk or posedge rst_bloom) begin
    if (rst_bloom) begin
      v1   <= 1'b0;
      eop1 <= 1'b0;
      h0_r <= '0;
      h1_r <= '0;
    end else begin
      v1   <= hash_en;
      eop1 <= beat && is_last;
      if (hash_en) begin
        h0_r <= fold(hash_data);
        h1_r <= fold(hash_rev);
      end
    end
  end

  assign hit = filter[h0_r] & filter[h1_r];

  // A new packet start wins over a lookup still draining from the previous packet.
  always_ff @(posedge clk or posedge rst_bloom) begin
    if (rst_bloom) begin
      bloom_match  <= 1'b0;
      scan_done    <= 1'b0;
      words_hashed <= 8'd0;
    end else begin
      scan_done <= eop1;
      if (pkt_start) begin
        bloom_match  <= 1'b0;
        words_hashed <= 8'd0;
      end else if (v1) begin
        if (hit) bloom_match <= 1'b1;
        if (words_hashed != 8'hFF) words_hashed <= words_hashed + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bloom_stream_scanner.sv
// Directed bench for bloom_stream_scanner; expectations are hand-derived fold hashes
// (64'h1 -> h0=1, h1=64; 64'hDEADBEEF -> h0=0x169; masked/zero words -> 0/0).
module tb_bloom_stream_scanner;
  logic       clk = 1'b0;
  logic       rst_bloom;
  logic       prog_we;
  logic [9:0] prog_addr;
  logic       prog_bit;
  logic       bloom_match, scan_done;
  logic [7:0] words_hashed;
  logic [2:0] scan_state;
  int         total = 0;
  int         bad = 0;

  bloom_stream_scanner_if sif ();

  bloom_stream_scanner dut (
    .clk          (clk),
    .rst_bloom    (rst_bloom),
    .stream       (sif),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_bit     (prog_bit),
    .bloom_match  (bloom_match),
    .scan_done    (scan_done),
    .words_hashed (words_hashed),
    .scan_state   (scan_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] c);
    sif.in_data = d;
    sif.in_ctrl = c;
    sif.in_wr   = 1'b1;
    sif.in_rdy  = 1'b1;
    tick();
    sif.in_wr   = 1'b0;
  endtask

  task automatic program_bit(input logic [9:0] a, input logic b);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_bit  = b;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic send_head();
    send(64'h0, 8'hFF);
    send(64'h0, 8'h00);
    send(64'h0, 8'h00);
  endtask

  task automatic test_reset();
    total++; if (bloom_match !== 1'b0) begin bad++; $display("FAIL reset_match: got %0h want 0", bloom_match); end
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0h want 0", scan_done); end
    total++; if (words_hashed !== 8'd0) begin bad++; $display("FAIL reset_words: got %0d want 0", words_hashed); end
    total++; if (scan_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", scan_state); end
  endtask

  task automatic test_match();
    program_bit(10'd1, 1'b1);
    program_bit(10'd64, 1'b1);
    send_head();
    total++; if (scan_state !== 3'd3) begin bad++; $display("FAIL match_scan_state: got %0d want 3", scan_state); end
    send(64'h1, 8'h00);
    total++; if (bloom_match !== 1'b0) begin bad++; $display("FAIL match_early: got %0h want 0", bloom_match); end
    send(64'hDEADBEEF, 8'h80);
    total++; if (bloom_match !== 1'b1) begin bad++; $display("FAIL match_rise: got %0h want 1", bloom_match); end
    total++; if (scan_state !== 3'd4) begin bad++; $display("FAIL match_done_state: got %0d want 4", scan_state); end
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL match_done_early: got %0h want 0", scan_done); end
    tick();
    total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL match_done: got %0h want 1", scan_done); end
    total++; if (words_hashed !== 8'd2) begin bad++; $display("FAIL match_words: got %0d want 2", words_hashed); end
    tick();
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL match_done_pulse: got %0h want 0", scan_done); end
    total++; if (bloom_match !== 1'b1) begin bad++; $display("FAIL match_sticky: got %0h want 1", bloom_match); end
  endtask

  task automatic test_no_match();
    program_bit(10'd64, 1'b0);
    send(64'h0, 8'hFF);
    total++; if (bloom_match !== 1'b0) begin bad++; $display("FAIL newpkt_clear: got %0h want 0", bloom_match); end
    total++; if (words_hashed !== 8'd0) begin bad++; $display("FAIL newpkt_words: got %0d want 0", words_hashed); end
    send(64'h0, 8'h00);
    send(64'h0, 8'h00);
    send(64'h1, 8'h00);
    send(64'hDEADBEEF, 8'h80);
    tick();
    total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL nomatch_done: got %0h want 1", scan_done); end
    total++; if (bloom_match !== 1'b0) begin bad++; $display("FAIL nomatch_match: got %0h want 0", bloom_match); end
    total++; if (words_hashed !== 8'd2) begin bad++; $display("FAIL nomatch_words: got %0d want 2", words_hashed); end
  endtask

  task automatic test_skip();
    program_bit(10'd64, 1'b1);
    send(64'h0, 8'hFF);
    send(64'h0, 8'h00);
    send(64'h1, 8'h00);
    send(64'hDEADBEEF, 8'h80);
    tick();
    total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL skip_done: got %0h want 1", scan_done); end
    total++; if (bloom_match !== 1'b0) begin bad++; $display("FAIL skip_match: got %0h want 0", bloom_match); end
    total++; if (words_hashed !== 8'd1) begin bad++; $display("FAIL skip_words: got %0d want 1", words_hashed); end
  endtask

  task automatic test_tail();
    logic exp_match;
`ifdef BLOOM_TAIL_MASK_EN
    exp_match = 1'b0;
`else
    exp_match = 1'b1;
`endif
    send_head();
    send(64'h1, 8'h80);
    tick();
    total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL tail_done: got %0h want 1", scan_done); end
    total++; if (bloom_match !== exp_match) begin bad++; $display("FAIL tail_match: got %0h want %0h", bloom_match, exp_match); end
    total++; if (words_hashed !== 8'd1) begin bad++; $display("FAIL tail_words: got %0d want 1", words_hashed); end
  endtask

  task automatic test_short();
    send(64'h0, 8'hFF);
    send(64'hDEADBEEF, 8'h80);
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL short_done_early: got %0h want 0", scan_done); end
    tick();
    total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL short_done: got %0h want 1", scan_done); end
    total++; if (bloom_match !== 1'b0) begin bad++; $display("FAIL short_match: got %0h want 0", bloom_match); end
    total++; if (words_hashed !== 8'd0) begin bad++; $display("FAIL short_words: got %0d want 0", words_hashed); end
  endtask

  task automatic test_back_to_back();
    send_head();
    send(64'h0, 8'h00);
    sif.in_wr  = 1'b1;
    sif.in_rdy = 1'b0;
    tick();
    send(64'h0, 8'h00);
    send(64'hDEADBEEF, 8'h80);
    tick();
    total++; if (words_hashed !== 8'd3) begin bad++; $display("FAIL b2b_words: got %0d want 3", words_hashed); end
    total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %0h want 1", scan_done); end
    send_head();
    for (int i = 0; i < 300; i++) send(64'h0, 8'h00);
    send(64'hDEADBEEF, 8'h80);
    tick();
    total++; if (words_hashed !== 8'd255) begin bad++; $display("FAIL sat_words: got %0d want 255", words_hashed); end
    total++; if (bloom_match !== 1'b0) begin bad++; $display("FAIL sat_match: got %0h want 0", bloom_match); end
  endtask

  task automatic test_reset_mid();
    send_head();
    send(64'h1, 8'h00);
    rst_bloom = 1'b1;
    #1;
    total++; if (bloom_match !== 1'b0) begin bad++; $display("FAIL rstmid_match: got %0h want 0", bloom_match); end
    total++; if (scan_state !== 3'd0) begin bad++; $display("FAIL rstmid_state: got %0d want 0", scan_state); end
    tick();
    rst_bloom = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (scan_done !== 1'b0 || bloom_match !== 1'b0) begin
        bad++; $display("FAIL rstmid_quiet: got done=%0h match=%0h want 0 0", scan_done, bloom_match);
      end
    end
    send_head();
    send(64'h1, 8'h00);
    send(64'hDEADBEEF, 8'h80);
    tick();
    total++; if (bloom_match !== 1'b1) begin bad++; $display("FAIL rstmid_resend: got %0h want 1", bloom_match); end
    total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL rstmid_resend_done: got %0h want 1", scan_done); end
  endtask

  task automatic test_prog_collide();
    send_head();
    send(64'h1, 8'h00);
    prog_we     = 1'b1;
    prog_addr   = 10'd64;
    prog_bit    = 1'b0;
    sif.in_data = 64'hDEADBEEF;
    sif.in_ctrl = 8'h80;
    sif.in_wr   = 1'b1;
    tick();
    prog_we   = 1'b0;
    sif.in_wr = 1'b0;
    total++; if (bloom_match !== 1'b1) begin bad++; $display("FAIL collide_hit: got %0h want 1", bloom_match); end
    tick();
    send_head();
    send(64'h1, 8'h00);
    send(64'hDEADBEEF, 8'h80);
    tick();
    total++; if (bloom_match !== 1'b0) begin bad++; $display("FAIL collide_after: got %0h want 0", bloom_match); end
    total++; if (scan_done !== 1'b1) begin bad++; $display("FAIL collide_after_done: got %0h want 1", scan_done); end
  endtask

  initial begin
    rst_bloom   = 1'b1;
    prog_we     = 1'b0;
    prog_addr   = 10'd0;
    prog_bit    = 1'b0;
    sif.in_data = 64'h0;
    sif.in_ctrl = 8'h00;
    sif.in_wr   = 1'b0;
    sif.in_rdy  = 1'b1;
    for (int i = 0; i < 1024; i++) program_bit(10'(i), 1'b0);
    rst_bloom = 1'b0;
    tick();
    test_reset();
    test_match();
    test_no_match();
    test_skip();
    test_tail();
    test_short();
    test_back_to_back();
    test_reset_mid();
    test_prog_collide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
